// File: rtl/seq_detector_pkg.sv
// Shared types and limits for the programmable serial sequence detector.
package seq_detector_pkg;

    localparam int unsigned PAT_W_MAX = 32;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/seq_detector_prog_cmp.sv
// Combinational masked compare of the shift window {hist,x} against the pattern.
module seq_match_cmp #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic [PAT_W-1:0] hist_i,
    input  logic             x_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             eq_o
);

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;

    always_comb begin
        window = {hist_i[PAT_W-2:0], x_i};
        mask   = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len_i));
        end
        eq_o = ~|((window ^ pat_i) & mask);
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with Mealy match flag.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter.
module seq_detector_prog
    import seq_detector_pkg::*;
#(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       x,
    input  logic                       x_valid,
    input  logic                       load,
    input  logic [PAT_W-1:0]           pat,
    input  logic [$clog2(PAT_W+1)-1:0] pat_len,
    input  logic                       overlap,
    input  logic                       cnt_clr,
    output logic                       z,
    output logic                       armed,
    output logic                       cfg_err,
    output logic [CNT_W-1:0]           match_cnt
);

    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             armed_q;
    logic             cfg_err_q, cfg_err_d;

    logic             eq;
    logic             legal;
    logic             reached;
    logic [LEN_W:0]   fill_p1;
    logic             z_int;

    seq_match_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .hist_i (hist_q),
        .x_i    (x),
        .pat_i  (pat_q),
        .len_i  (len_q),
        .eq_o   (eq)
    );

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cfg_err_d = cfg_err_q;

        legal   = (pat_len != '0) && (32'(pat_len) <= PAT_W) && (PAT_W <= PAT_W_MAX);
        fill_p1 = {1'b0, fill_q} + 1'b1;
        reached = (fill_p1 >= {1'b0, len_q});
        z_int   = x_valid && !load && (state_q != UNCFG) && reached && eq;

        if (load) begin
            if (legal) begin
                pat_d     = pat;
                len_d     = pat_len;
                ovl_d     = overlap;
                hist_d    = '0;
                fill_d    = '0;
                cfg_err_d = 1'b0;
                state_d   = FILL;
            end else begin
                cfg_err_d = 1'b1;
                state_d   = UNCFG;
            end
        end else if (x_valid) begin
            // Non-overlapping mode restarts the window after every hit.
            if (z_int && !ovl_q) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILL;
            end else begin
                hist_d = {hist_q[PAT_W-2:0], x};
                if (fill_q != LEN_W'(PAT_W)) begin
                    fill_d = fill_q + 1'b1;
                end
                if (state_q == FILL && reached) begin
                    state_d = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNCFG;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            armed_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            armed_q   <= (state_d == RUN);
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load && legal) begin
            cnt_d = '0;
        end else if (cnt_clr) begin
            cnt_d = z_int ? CNT_W'(1) : '0;
        end else if (z_int && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

    assign z       = z_int;
    assign armed   = armed_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog (PAT_W=8, CNT_W=2).
module tb_seq_detector_prog;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 2;
    localparam int          CNT_MAX = 3;
`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, x, x_valid, load, overlap, cnt_clr;
    logic [PAT_W-1:0] pat;
    logic [3:0]       pat_len;
    logic             z, armed, cfg_err;
    logic [CNT_W-1:0] match_cnt;

    always #5 clk = ~clk;

    seq_detector_prog #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .x_valid   (x_valid),
        .load      (load),
        .pat       (pat),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .z         (z),
        .armed     (armed),
        .cfg_err   (cfg_err),
        .match_cnt (match_cnt)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    string phase = "init";
    logic  exp_q[$];

    // Reference model: 0=UNCFG 1=FILL 2=RUN
    int          m_state = 0;
    logic [31:0] m_hist = '0;
    logic [31:0] m_pat = '0;
    int          m_len = 0;
    int          m_fill = 0;
    logic        m_ovl = 1'b0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, act, exp, $time);
        end
    endtask

    function automatic logic model_z();
        logic [63:0] mask, win, p;
        if (rst || load || !x_valid || m_state == 0) return 1'b0;
        if (m_fill + 1 < m_len) return 1'b0;
        mask = (64'd1 << m_len) - 64'd1;
        win  = {31'b0, m_hist, x};
        p    = {32'b0, m_pat};
        return ((win & mask) == (p & mask));
    endfunction

    task automatic model_update(input logic ez);
        if (rst) begin
            m_state = 0; m_hist = '0; m_fill = 0; m_err = 1'b0; m_cnt = 0; m_len = 0;
        end else if (load) begin
            if (pat_len >= 1 && pat_len <= PAT_W) begin
                m_pat = {24'b0, pat}; m_len = int'(pat_len); m_ovl = overlap;
                m_hist = '0; m_fill = 0; m_cnt = 0; m_err = 1'b0; m_state = 1;
            end else begin
                m_state = 0; m_err = 1'b1;
            end
        end else begin
            if (cnt_clr) m_cnt = ez ? 1 : 0;
            else if (ez && m_cnt < CNT_MAX) m_cnt++;
            if (x_valid) begin
                if (ez && !m_ovl) begin
                    m_hist = '0; m_fill = 0; m_state = 1;
                end else begin
                    m_hist = {m_hist[30:0], x};
                    if (m_fill < PAT_W) m_fill++;
                    if (m_state == 1 && m_fill >= m_len) m_state = 2;
                end
            end
        end
    endtask

    task automatic step(input logic xv, input logic xb, input logic ld, input logic clr, input logic rs);
        logic ez;
        x_valid = xv; x = xb; load = ld; cnt_clr = clr; rst = rs;
        exp_q.push_back(model_z());
        @(negedge clk);
        ez = exp_q.pop_front();
        check("z", {31'b0, z}, {31'b0, ez});
        @(posedge clk);
        model_update(ez);
        #1;
        check("armed", {31'b0, armed}, {31'b0, m_state == 2});
        check("cfg_err", {31'b0, cfg_err}, {31'b0, m_err});
        check("match_cnt", {30'b0, match_cnt}, CNT_EN ? 32'(m_cnt) : 32'd0);
    endtask

    task automatic do_load(input logic [PAT_W-1:0] p, input logic [3:0] len, input logic ovl);
        pat = p; pat_len = len; overlap = ovl;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send(input logic b);
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0] s38;
        rst = 1'b1; x = 1'b0; x_valid = 1'b0; load = 1'b0; cnt_clr = 1'b0;
        overlap = 1'b0; pat = '0; pat_len = '0;
        repeat (2) @(posedge clk);
        #1;

        phase = "reset";
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b1); send(1'b0); send(1'b1);

        phase = "p001";
        do_load(8'b001, 4'd3, 1'b0);
        send(1'b1); send(1'b0); send(1'b0); send(1'b0); send(1'b1);

        s38 = 6'b010101;
        phase = "p0101_ovl";
        do_load(8'b0101, 4'd4, 1'b1);
        for (int i = 5; i >= 0; i--) send(s38[i]);
        phase = "p0101_novl";
        do_load(8'b0101, 4'd4, 1'b0);
        for (int i = 5; i >= 0; i--) send(s38[i]);

        phase = "cfg_err";
        do_load(8'b1, 4'd0, 1'b1);
        send(1'b1); send(1'b1);
        do_load(8'b1, 4'd9, 1'b1);
        send(1'b1); send(1'b1);
        do_load(8'b1, 4'd1, 1'b1);

        phase = "sat";
        for (int i = 0; i < 6; i++) send(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        phase = "gap";
        do_load(8'b11, 4'd2, 1'b1);
        send(1'b1); idle(); idle(); idle(); send(1'b1);
        phase = "rst_mid";
        do_load(8'b11, 4'd2, 1'b1);
        send(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b1); send(1'b1);

        phase = "load_prio";
        do_load(8'b11, 4'd2, 1'b0);
        send(1'b1);
        pat = 8'b11; pat_len = 4'd2; overlap = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b0); send(1'b1); send(1'b1);

        phase = "full_len";
        do_load(8'hA5, 4'd8, 1'b1);
        for (int i = 0; i < 24; i++) send(i[0] ^ i[2]);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_load(PAT_W'($urandom), 4'($urandom_range(0, 9)), 1'($urandom));
            end else begin
                step(($urandom_range(0, 9) < 7), 1'($urandom), 1'b0,
                     ($urandom_range(0, 14) == 0), ($urandom_range(0, 149) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
